hamming_frame_deserializer: RTL and testbench
=============================================

# hamming_frame_deserializer

Serial-to-parallel front end for the 2-D Hamming decode path. It hunts a serial bit stream for a sync word, then captures the following 60 channel bits into one encoded frame. It presents that frame to the 60-bit-input 2-D Hamming decoder through a valid/ready handshake. It buffers one frame and counts frames that are dropped because the decoder side is stalled.

## Interface
- SYNC_LEN, 8, sync word length in bits (2..16)
- SYNC_WORD, 8'hA5, sync pattern, transmitted MSB first
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- bit_in  in  1  serial channel bit
- bit_valid  in  1  bit_in sampled on this edge when 1; no backpressure
- encoded_out  out  60  captured frame; channel bit k of payload lands in encoded_out[k]
- out_valid  out  1  encoded_out holds an unconsumed frame
- out_ready  in  1  downstream accepts frame
- locked  out  1  1 while collecting payload (COLLECT state)
- overflow  out  1  one-cycle pulse when a completed frame is dropped
- frame_count  out  16  frames delivered (handshake completed), wraps at 16'hFFFF→0
- drop_count  out  8  frames dropped, saturates at 8'hFF

## Operation
- Reset (async, rst_n=0): state=HUNT, sync shift register=0, bit counter=0, payload shift=0, encoded_out=0, out_valid=0, locked=0, overflow=0, frame_count=0, drop_count=0.
- HUNT: on each edge with bit_valid=1, sync_sr <= {sync_sr[SYNC_LEN-2:0], bit_in}. If the new sync_sr value equals SYNC_WORD, go to COLLECT with bit counter=0. Bits with bit_valid=0 are ignored in all states.
- COLLECT: locked=1. Each valid bit is written to payload bit [counter], and the counter increments. On the 60th valid bit (counter==59), the frame completes: the state returns to HUNT, and both sync_sr and the counter clear to 0. Sync patterns inside the payload are not detected.
- Frame completion with output slot free: encoded_out <= assembled payload, and out_valid <= 1.
- The output slot is free when out_valid=0, or when out_valid=1 and out_ready=1 on the same edge. In the second case, the old frame is delivered, the new frame is loaded, and out_valid stays 1.
- Frame completion with slot occupied and out_ready=0: the new frame is discarded, encoded_out is unchanged, overflow pulses for 1 cycle, and drop_count increments (saturating).
- Handshake: a transfer occurs on an edge with out_valid=1 and out_ready=1. The transfer increments frame_count. out_valid falls after the edge unless a frame completes on the same edge.
- encoded_out is stable while out_valid=1 and no transfer occurs. out_ready while out_valid=0 has no effect.
- Parameters are checked at elaboration: SYNC_LEN outside 2..16 is a fatal error.

## Timing
- Sync detect: COLLECT is entered on the edge sampling the last sync bit. The first payload bit can arrive on the very next edge.
- Frame latency: out_valid and encoded_out are registered. Both update on the same edge that samples payload bit 59, and are visible the following cycle.
- Minimum frame period: SYNC_LEN+60 valid bits. With back-to-back bits, a new frame can complete every 68 cycles at default parameters.
- overflow is high for exactly one cycle, the cycle after the dropping edge.
- Mid-operation reset: rst_n assertion immediately clears all state, including any partial payload and the held frame. After deassertion the block restarts in HUNT, and no stale frame is emitted.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Basic: reset, then send A5 (MSB first) followed by 60'h0123456789ABCDE (LSB first), bit_valid=1 throughout, out_ready=1. Required: out_valid rises 1 cycle after bit 59, encoded_out=60'h0123456789ABCDE, frame_count=1, locked falls after bit 59.
- Gapped bits: same frame with bit_valid toggling 1/0 every cycle. Required: identical encoded_out; latency is counted in valid bits, not cycles.
- False/embedded sync: send 8'hA4, then A5, then a payload containing 8'hA5 at bits 10..17. Required: exactly one frame is captured, aligned to the second byte, and the payload A5 is not re-synced.
- Backpressure/drop: out_ready=0 while two frames 60'h1 and 60'h2 arrive. Required: encoded_out stays 60'h1, overflow pulses once, drop_count=1. Then raise out_ready: frame_count=1 and out_valid falls.
- Simultaneous: frame 60'h3 completes on the same edge that frame 60'h2 is accepted. Required: no drop, out_valid stays 1, encoded_out=60'h3.
- Reset mid-frame: assert rst_n=0 after 30 payload bits, release it, then send a full new frame 60'hFFF. Required: all outputs read 0 during reset, and only 60'hFFF is delivered with frame_count=1.

Source files
------------

// File: rtl/hamming_frame_deserializer.sv
// hamming_frame_deserializer
// Hunts a serial bit stream for SYNC_WORD (MSB first), then captures the next
// 60 valid channel bits (bit k -> encoded_out[k]) into a one-deep output slot
// presented to the 2-D Hamming decoder over valid/ready.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   bit_in, bit_valid       serial channel bit and its qualifier (no backpressure)
//   encoded_out, out_valid  held frame and its valid flag
//   out_ready               downstream accepts the held frame
//   locked                  high while collecting payload
//   overflow                one-cycle pulse when a completed frame is dropped
//   frame_count             delivered frames (wrapping)
//   drop_count              dropped frames (saturating)
module hamming_frame_deserializer #(
    parameter int unsigned             SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0]     SYNC_WORD = SYNC_LEN'(8'hA5)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic [59:0] encoded_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        locked,
    output logic        overflow,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count
);

    localparam int unsigned FRAME_W = 60;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned FC_W    = 16;
    localparam int unsigned DC_W    = 8;

    // Elaboration-time parameter guard
    if (SYNC_LEN < 2 || SYNC_LEN > 16) begin : g_bad_sync_len
        $fatal(1, "hamming_frame_deserializer: SYNC_LEN must be in 2..16");
    end

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_LEN-1:0]  sync_q, sync_d, sync_shift;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   payload_q, payload_d;
    logic [FRAME_W-1:0]   encoded_q, encoded_d;
    logic                 out_valid_q, out_valid_d;
    logic                 locked_q;
    logic                 overflow_q, overflow_d;
    logic [FC_W-1:0]      frame_count_q, frame_count_d;
    logic [DC_W-1:0]      drop_count_q, drop_count_d;

    logic frame_done;
    logic sync_hit;
    logic xfer;
    logic slot_free;

    assign sync_shift = {sync_q[SYNC_LEN-2:0], bit_in};
    assign sync_hit   = (state_q == HUNT) && bit_valid && (sync_shift == SYNC_WORD);
    assign frame_done = (state_q == COLLECT) && bit_valid && (cnt_q == CNT_W'(FRAME_W - 1));
    assign xfer       = out_valid_q && out_ready;
    // Slot is free if empty or being drained on this same edge
    assign slot_free  = !out_valid_q || out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (sync_hit)   state_d = COLLECT;
            COLLECT: if (frame_done) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        sync_d        = sync_q;
        cnt_d         = cnt_q;
        payload_d     = payload_q;
        encoded_d     = encoded_q;
        out_valid_d   = out_valid_q;
        overflow_d    = 1'b0;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;

        case (state_q)
            HUNT: begin
                cnt_d = '0;
                if (bit_valid) sync_d = sync_shift;
            end
            COLLECT: begin
                if (bit_valid) begin
                    payload_d[cnt_q] = bit_in;
                    if (frame_done) begin
                        cnt_d  = '0;
                        sync_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if (xfer) begin
            frame_count_d = frame_count_q + FC_W'(1);
            out_valid_d   = 1'b0;
        end

        if (frame_done) begin
            if (slot_free) begin
                encoded_d   = payload_d;
                out_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (drop_count_q != '1) drop_count_d = drop_count_q + DC_W'(1);
            end
        end
    end

    // Datapath / output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            cnt_q         <= '0;
            payload_q     <= '0;
            encoded_q     <= '0;
            out_valid_q   <= 1'b0;
            locked_q      <= 1'b0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            payload_q     <= payload_d;
            encoded_q     <= encoded_d;
            out_valid_q   <= out_valid_d;
            locked_q      <= (state_d == COLLECT);
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign encoded_out = encoded_q;
    assign out_valid   = out_valid_q;
    assign locked      = locked_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_hamming_frame_deserializer.sv
// Testbench for hamming_frame_deserializer: directed frames, expected frames
// queued at stimulus time and checked by an independent handshake monitor.
module tb_hamming_frame_deserializer;

    logic        clk;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic [59:0] encoded_out;
    logic        out_valid;
    logic        out_ready;
    logic        locked;
    logic        overflow;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;

    int n_tests;
    int n_fail;
    logic [59:0] exp_q[$];

    hamming_frame_deserializer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .encoded_out (encoded_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .locked      (locked),
        .overflow    (overflow),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid&ready now
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_frame: got %0h expected none", encoded_out);
            end else begin
                logic [59:0] e;
                e = exp_q.pop_front();
                if (encoded_out !== e) begin
                    n_fail++;
                    $display("FAIL frame_data: got %0h expected %0h", encoded_out, e);
                end
            end
        end
    end

    // Inputs change 1 time unit after the rising edge
    task automatic send_bit(input logic b, input bit gap);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_sync(input logic [7:0] w, input bit gap);
        for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
    endtask

    task automatic send_payload(input logic [59:0] p, input bit gap);
        for (int i = 0; i < 60; i++) send_bit(p[i], gap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_encoded"},  64'(encoded_out), 64'h0);
        check({tag, "_valid"},    64'(out_valid),   64'h0);
        check({tag, "_locked"},   64'(locked),      64'h0);
        check({tag, "_overflow"}, 64'(overflow),    64'h0);
        check({tag, "_fcount"},   64'(frame_count), 64'h0);
        check({tag, "_dcount"},   64'(drop_count),  64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [59:0] p;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b1;

        // Reset state
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Basic frame, back-to-back bits
        p = 60'h0123456789ABCDE;
        send_sync(8'hA5, 1'b0);
        check("basic_locked_after_sync", 64'(locked), 64'h1);
        exp_q.push_back(p);
        for (int i = 0; i < 59; i++) send_bit(p[i], 1'b0);
        check("basic_valid_before_last", 64'(out_valid), 64'h0);
        check("basic_locked_before_last", 64'(locked), 64'h1);
        send_bit(p[59], 1'b0);
        check("basic_valid_after_last", 64'(out_valid), 64'h1);
        check("basic_encoded", 64'(encoded_out), 64'(60'h0123456789ABCDE));
        check("basic_locked_after_last", 64'(locked), 64'h0);
        idle(1);
        check("basic_fcount", 64'(frame_count), 64'd1);
        check("basic_valid_fall", 64'(out_valid), 64'h0);

        // Gapped bits: latency in valid bits
        exp_q.push_back(p);
        send_sync(8'hA5, 1'b1);
        for (int i = 0; i < 59; i++) send_bit(p[i], 1'b1);
        check("gap_valid_before_last", 64'(out_valid), 64'h0);
        bit_in = p[59]; bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        check("gap_valid_after_last", 64'(out_valid), 64'h1);
        check("gap_encoded", 64'(encoded_out), 64'(60'h0123456789ABCDE));
        idle(2);
        check("gap_fcount", 64'(frame_count), 64'd2);

        // False sync A4, then A5, payload with A5 at bits 10..17
        p = 60'h000000000029403;
        send_sync(8'hA4, 1'b0);
        check("false_sync_not_locked", 64'(locked), 64'h0);
        send_sync(8'hA5, 1'b0);
        exp_q.push_back(p);
        for (int i = 0; i < 20; i++) send_bit(p[i], 1'b0);
        check("embedded_still_locked", 64'(locked), 64'h1);
        for (int i = 20; i < 60; i++) send_bit(p[i], 1'b0);
        check("embedded_encoded", 64'(encoded_out), 64'(60'h000000000029403));
        check("embedded_unlocked", 64'(locked), 64'h0);
        idle(4);
        check("embedded_fcount", 64'(frame_count), 64'd3);

        // Backpressure: frame 1 held, frame 2 dropped
        out_ready = 1'b0;
        exp_q.push_back(60'h1);
        send_sync(8'hA5, 1'b0);
        send_payload(60'h1, 1'b0);
        send_sync(8'hA5, 1'b0);
        check("bp_no_overflow_yet", 64'(overflow), 64'h0);
        send_payload(60'h2, 1'b0);
        check("bp_overflow_pulse", 64'(overflow), 64'h1);
        check("bp_dcount", 64'(drop_count), 64'd1);
        check("bp_encoded_held", 64'(encoded_out), 64'h1);
        idle(1);
        check("bp_overflow_fall", 64'(overflow), 64'h0);
        out_ready = 1'b1;
        idle(1);
        check("bp_fcount", 64'(frame_count), 64'd4);
        check("bp_valid_fall", 64'(out_valid), 64'h0);

        // Simultaneous: frame 3 completes on the edge frame 2 is accepted
        out_ready = 1'b0;
        exp_q.push_back(60'h2);
        send_sync(8'hA5, 1'b0);
        send_payload(60'h2, 1'b0);
        p = 60'h3;
        exp_q.push_back(p);
        send_sync(8'hA5, 1'b0);
        for (int i = 0; i < 59; i++) send_bit(p[i], 1'b0);
        out_ready = 1'b1;
        send_bit(p[59], 1'b0);
        check("simul_valid", 64'(out_valid), 64'h1);
        check("simul_encoded", 64'(encoded_out), 64'h3);
        check("simul_overflow", 64'(overflow), 64'h0);
        check("simul_dcount", 64'(drop_count), 64'd1);
        check("simul_fcount_first", 64'(frame_count), 64'd5);
        idle(1);
        check("simul_fcount", 64'(frame_count), 64'd6);

        // Reset mid-frame with a frame held in the slot
        out_ready = 1'b0;
        send_sync(8'hA5, 1'b0);
        send_payload(60'h5, 1'b0);
        check("rst_held_valid", 64'(out_valid), 64'h1);
        p = 60'hABCDEF012345678;
        send_sync(8'hA5, 1'b0);
        for (int i = 0; i < 30; i++) send_bit(p[i], 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);
        check("post_rst_valid", 64'(out_valid), 64'h0);
        p = 60'hFFF;
        exp_q.push_back(p);
        send_sync(8'hA5, 1'b0);
        send_payload(p, 1'b0);
        check("post_rst_encoded", 64'(encoded_out), 64'hFFF);
        idle(3);
        check("post_rst_fcount", 64'(frame_count), 64'd1);
        check("post_rst_dcount", 64'(drop_count), 64'd0);

        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
